total_alu: RTL and testbench

32-bit ALU with an integrated sequential unsigned multiplier and HI/LO result registers, sitting in the execute stage of the pipelined MIPS-style CPU. Logic, arithmetic, compare and shift results come out combinationally. MULTU runs a 32-cycle shift-add iteration into a 64-bit accumulator and latches the result into HI/LO. MFHI and MFLO then read the latched halves back through the same output.

---
 rtl/total_alu_if.sv | 26 ++
 rtl/total_alu.sv | 90 +++++++++
 tb/tb_total_alu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/total_alu_if.sv
// Execute-stage ALU bus: operands and function code in, result out.
//   dataA  - operand A (multiplicand for MULTU, shifted value for SLL)
//   dataB  - operand B (multiplier for MULTU, shift amount for SLL)
//   Signal - 6-bit MIPS funct code
//   Output - 32-bit result
// master drives operands/code and reads the result; slave is the ALU side.
interface total_alu_if;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] Output;

  modport master (
    output dataA,
    output dataB,
    output Signal,
    input  Output
  );

  modport slave (
    input  dataA,
    input  dataB,
    input  Signal,
    output Output
  );
endinterface

// File: rtl/total_alu.sv
// 32-bit ALU with a sequential shift-add unsigned multiplier and HI/LO registers.
// Logic, arithmetic, compare and shift results are combinational. MULTU iterates
// one multiplier bit per clock for 32 clocks and latches the 64-bit product into
// HI/LO; MFHI/MFLO read the halves back on the result output.
//   clk   - clock, state updates on rising edge
//   reset - synchronous, active-high; clears accumulator, counter, HI and LO
//   bus   - total_alu_if.slave: dataA, dataB, Signal in; Output out
module total_alu (
  input  logic        clk,
  input  logic        reset,
  total_alu_if.slave  bus
);

  localparam logic [5:0] FnSll   = 6'd0;
  localparam logic [5:0] FnMfhi  = 6'd16;
  localparam logic [5:0] FnMflo  = 6'd18;
  localparam logic [5:0] FnMultu = 6'd25;
  localparam logic [5:0] FnAdd   = 6'd32;
  localparam logic [5:0] FnSub   = 6'd34;
  localparam logic [5:0] FnAnd   = 6'd36;
  localparam logic [5:0] FnOr    = 6'd37;
  localparam logic [5:0] FnSlt   = 6'd42;

  localparam logic [5:0] IterLast = 6'd31;
  localparam logic [5:0] IterDone = 6'd32;

  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result;

  // Multiplier next state. Any non-MULTU code aborts a partial multiply, which is
  // also how software re-arms the unit between products; HI/LO survive it.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (bus.Signal == FnMultu) begin
      // Once cnt reaches 32 the unit holds until a non-MULTU cycle or reset.
      if (cnt_q < IterDone) begin
        if (bus.dataB[cnt_q[4:0]]) begin
          acc_d = acc_q + ({32'b0, bus.dataA} << cnt_q[4:0]);
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == IterLast) begin
          hi_d = acc_d[63:32];
          lo_d = acc_d[31:0];
        end
      end
    end else begin
      acc_d = 64'd0;
      cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 64'd0;
      cnt_q <= 6'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Result mux; MULTU and unknown codes read as zero.
  always_comb begin
    result = 32'd0;
    case (bus.Signal)
      FnAnd:   result = bus.dataA & bus.dataB;
      FnOr:    result = bus.dataA | bus.dataB;
      FnAdd:   result = bus.dataA + bus.dataB;
      FnSub:   result = bus.dataA - bus.dataB;
      FnSlt:   result = {31'b0, ($signed(bus.dataA) < $signed(bus.dataB))};
      FnSll:   result = bus.dataA << bus.dataB[4:0];
      FnMfhi:  result = hi_q;
      FnMflo:  result = lo_q;
      default: result = 32'd0;
    endcase
  end

  assign bus.Output = result;

endmodule

// File: tb/tb_total_alu.sv
// Self-checking bench for total_alu: directed cases followed by randomized
// operations and multiply runs, compared against an arithmetic reference model.
module tb_total_alu;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  // Reference model state: number of consecutive MULTU edges and latched product.
  int          m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  total_alu_if bus ();

  total_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_out(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] sig);
    int unsigned sh;
    longint unsigned wide;
    sh = b % 32;
    case (sig)
      6'd36: return a & b;
      6'd37: return a | b;
      6'd32: begin wide = longint'(a) + longint'(b); return wide[31:0]; end
      6'd34: begin wide = longint'(a) + (64'd1 << 32) - longint'(b); return wide[31:0]; end
      6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'd0:  begin wide = longint'(a) * (64'd1 << sh); return wide[31:0]; end
      6'd16: return m_hi;
      6'd18: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs at the falling edge, advance the model at the rising
  // edge, then compare the output shortly after it.
  task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input logic rst, input string tag);
    longint unsigned prod;
    @(negedge clk);
    bus.dataA  = a;
    bus.dataB  = b;
    bus.Signal = sig;
    reset      = rst;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
    end else if (sig == 6'd25) begin
      if (m_cnt < 32) begin
        m_cnt++;
        if (m_cnt == 32) begin
          prod = longint'(a) * longint'(b);
          m_hi = prod[63:32];
          m_lo = prod[31:0];
        end
      end
    end else begin
      m_cnt = 0;
    end
    #1;
    check(bus.Output, model_out(a, b, sig), tag);
  endtask

  task automatic multu_run(input logic [31:0] a, input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(a, b, 6'd25, 1'b0, "multu_busy");
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rs;
    errors = 0;
    checks = 0;
    m_cnt  = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    reset      = 1'b1;
    bus.dataA  = 32'd0;
    bus.dataB  = 32'd0;
    bus.Signal = 6'd0;

    cycle(32'd0, 32'd0, 6'd0, 1'b1, "reset");
    cycle(32'd0, 32'd0, 6'd16, 1'b0, "reset_mfhi");
    check(bus.Output, 32'd0, "reset_mfhi_const");
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "reset_mflo");
    check(bus.Output, 32'd0, "reset_mflo_const");

    cycle(32'd5, 32'd7, 6'd32, 1'b0, "add");
    check(bus.Output, 32'd12, "add_const");
    cycle(32'd3, 32'd5, 6'd34, 1'b0, "sub");
    check(bus.Output, 32'd4294967294, "sub_const");
    cycle(32'd12, 32'd10, 6'd36, 1'b0, "and");
    check(bus.Output, 32'd8, "and_const");
    cycle(32'd12, 32'd10, 6'd37, 1'b0, "or");
    check(bus.Output, 32'd14, "or_const");
    cycle(32'hFFFF_FFFF, 32'd1, 6'd42, 1'b0, "slt_neg");
    check(bus.Output, 32'd1, "slt_neg_const");
    cycle(32'd1, 32'hFFFF_FFFF, 6'd42, 1'b0, "slt_pos");
    check(bus.Output, 32'd0, "slt_pos_const");
    cycle(32'd5, 32'd5, 6'd42, 1'b0, "slt_eq");
    check(bus.Output, 32'd0, "slt_eq_const");
    cycle(32'd1, 32'd4, 6'd0, 1'b0, "sll_4");
    check(bus.Output, 32'd16, "sll_4_const");
    cycle(32'd3, 32'd31, 6'd0, 1'b0, "sll_31");
    check(bus.Output, 32'd2147483648, "sll_31_const");
    cycle(32'd1, 32'd36, 6'd0, 1'b0, "sll_36");
    check(bus.Output, 32'd16, "sll_36_const");
    cycle(32'd9, 32'd9, 6'd63, 1'b0, "undef_code");

    multu_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    cycle(32'd0, 32'd0, 6'd16, 1'b0, "max_mfhi");
    check(bus.Output, 32'd4294967294, "max_mfhi_const");
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "max_mflo");
    check(bus.Output, 32'd1, "max_mflo_const");

    multu_run(32'd100000, 32'd300000, 32);
    cycle(32'd0, 32'd0, 6'd16, 1'b0, "big_mfhi");
    check(bus.Output, 32'd6, "big_mfhi_const");
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "big_mflo");
    check(bus.Output, 32'd4230196224, "big_mflo_const");

    cycle(32'd0, 32'd0, 6'd18, 1'b1, "reset2");
    cycle(32'd0, 32'd0, 6'd16, 1'b0, "reset2_mfhi");
    check(bus.Output, 32'd0, "reset2_mfhi_const");
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "reset2_mflo");
    check(bus.Output, 32'd0, "reset2_mflo_const");

    // Abort with reset (same edge as MULTU), then a fresh full run.
    multu_run(32'd7, 32'd9, 10);
    cycle(32'd7, 32'd9, 6'd25, 1'b1, "abort_reset");
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "abort_mflo");
    check(bus.Output, 32'd0, "abort_mflo_const");
    multu_run(32'd7, 32'd9, 32);
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "rerun_mflo");
    check(bus.Output, 32'd63, "rerun_mflo_const");
    cycle(32'd0, 32'd0, 6'd16, 1'b0, "rerun_mfhi");
    check(bus.Output, 32'd0, "rerun_mfhi_const");

    // Completed unit holds: extra MULTU edges with new operands leave HI/LO alone.
    multu_run(32'd11, 32'd13, 32);
    multu_run(32'hDEAD_BEEF, 32'h1234_5678, 5);
    cycle(32'd0, 32'd0, 6'd18, 1'b0, "hold_mflo");
    check(bus.Output, 32'd143, "hold_mflo_const");

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: begin
          multu_run(ra, rb, int'($urandom_range(1, 40)));
          cycle(32'd0, 32'd0, 6'd16, 1'b0, "rand_mfhi");
          cycle(32'd0, 32'd0, 6'd18, 1'b0, "rand_mflo");
        end
        1: cycle(ra, rb, 6'd42, 1'b0, "rand_slt");
        2: cycle(ra, rb, 6'd0, 1'b0, "rand_sll");
        3: cycle(ra, rb, 6'(($urandom_range(0, 1) != 0) ? 32 : 34), 1'b0, "rand_addsub");
        4: begin
          rs = 6'($urandom);
          if (rs == 6'd25) rs = 6'd16;
          cycle(ra, rb, rs, ($urandom_range(0, 9) == 0), "rand_op");
        end
        default: cycle(ra, rb, 6'(($urandom_range(0, 1) != 0) ? 36 : 37), 1'b0, "rand_logic");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
